// File: rtl/group_scheduler_level_1.sv
// Level-1 round-robin scheduler: grants one level-0 pixel group at a time and holds it until release.
// Optional watchdog enabled by defining GRP_TIMEOUT_EN.
`timescale 1ns/1ps
module group_scheduler_level_1 #(
  parameter int GRP_ROWS = 4,
  parameter int GRP_COLS = 4,
  parameter int GRP_ADD  = 2,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [GRP_ROWS-1:0][GRP_COLS-1:0]  req_i,
  input  logic                               grp_release_i,
  input  logic                               active_i,
  output logic [GRP_ROWS-1:0][GRP_COLS-1:0]  enable_o,
  output logic [GRP_ADD-1:0]                 x_add_o,
  output logic [GRP_ADD-1:0]                 y_add_o,
  output logic                               busy_o,
  output logic [CNT_W-1:0]                   grant_cnt_o,
  output logic                               timeout_o
);

  localparam int N     = GRP_ROWS * GRP_COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if ((1 << GRP_ADD) < GRP_ROWS || (1 << GRP_ADD) < GRP_COLS || TIMEOUT < 1) begin : g_bad_params
    $error("group_scheduler_level_1: GRP_ADD too narrow or TIMEOUT < 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr_q;
  logic [N-1:0]     req_flat;
  logic [N-1:0]     onehot;
  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [GRP_ADD-1:0] win_row;
  logic [GRP_ADD-1:0] win_col;
  logic             release_hit;
  logic             wd_hit;

  assign req_flat = req_i;

  // Round-robin search upward from ptr_q+1; ptr_q holds the last winner.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_flat[IDX_W'((int'(ptr_q) + k) % N)]) begin
        found   = 1'b1;
        win_idx = IDX_W'((int'(ptr_q) + k) % N);
      end
    end
    onehot          = '0;
    onehot[win_idx] = 1'b1;
    win_row = GRP_ADD'(int'(win_idx) / GRP_COLS);
    win_col = GRP_ADD'(int'(win_idx) % GRP_COLS);
  end

  // A granted group that stopped requesting while level 0 is idle is treated as released.
  assign release_hit = grp_release_i || (!req_flat[ptr_q] && !active_i);

`ifdef GRP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_hit = (state == BUSY) && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (state != BUSY) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit && !release_hit) timeout_o <= 1'b1;
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      ptr_q       <= IDX_W'(N - 1);
      enable_o    <= '0;
      x_add_o     <= '0;
      y_add_o     <= '0;
      busy_o      <= 1'b0;
      grant_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            enable_o <= onehot;
            x_add_o  <= win_row;
            y_add_o  <= win_col;
            busy_o   <= 1'b1;
            ptr_q    <= win_idx;
            if (grant_cnt_o != '1) grant_cnt_o <= grant_cnt_o + 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_hit || wd_hit) begin
            enable_o <= '0;
            busy_o   <= 1'b0;
            state    <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/group_scheduler_level_1.md
Name: group_scheduler_level_1

Overview:
- Level-1 scheduler for the level-0 pixel-group array.
- Arbitrates between per-group requests (one bit per level-0 group) using round-robin.
- Drives a one-hot enable into the level-0 groups and holds it until the enabled group reports release.
- Outputs the granted group's row/column address for event address composition (group address concatenated with the level-0 pixel address).

Parameters:
GRP_ROWS, 4, number of level-0 group rows
GRP_COLS, 4, number of level-0 group columns
GRP_ADD, 2, width of the group row/column address; must satisfy 2**GRP_ADD >= max(GRP_ROWS, GRP_COLS)
CNT_W, 16, width of the grant event counter
TIMEOUT, 255, watchdog limit in cycles (used only with GRP_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
req_i  in  [GRP_ROWS-1:0][GRP_COLS-1:0]  per-group request from level 0
grp_release_i  in  1  release pulse from the currently enabled level-0 group
active_i  in  1  level-0 arbitration active (OR of all groups)
enable_o  out  [GRP_ROWS-1:0][GRP_COLS-1:0]  one-hot group enable
x_add_o  out  GRP_ADD  row of the enabled group
y_add_o  out  GRP_ADD  column of the enabled group
busy_o  out  1  a group is currently enabled
grant_cnt_o  out  CNT_W  number of grants issued, saturating
timeout_o  out  1  sticky watchdog flag (tied 0 without GRP_TIMEOUT_EN)

Behaviour:
- Reset is asynchronous and active-high. Clock is clk_i; reset is reset_i.
- Reset values:
  - enable_o=0, x_add_o=0, y_add_o=0, busy_o=0, grant_cnt_o=0, timeout_o=0.
  - State=IDLE; round-robin pointer=GRP_ROWS*GRP_COLS-1, so the first search starts at index 0.
- Flat group index = row*GRP_COLS+col.
- State IDLE:
  - If |req_i, select the first set index searching upward from pointer+1, with wrap-around.
  - Registered on the next edge: enable_o one-hot at the winner, x_add_o=row, y_add_o=col, busy_o=1, pointer=winner, grant_cnt_o+1 (saturates at all-ones). Go to BUSY.
  - Latency: req_i seen at edge N produces enable_o valid after edge N.
- State BUSY:
  - enable_o, x_add_o and y_add_o are held stable. New requests from other groups are ignored.
  - grp_release_i=1 → enable_o=0, busy_o=0 next edge; go to GAP.
  - Abort: req_i of the granted group=0 and active_i=0 and no release → treat as release; go to GAP. The counter is not decremented.
- State GAP:
  - Exactly one cycle with enable_o=0 while level-0 req_o settles. Then go to IDLE.
  - Maximum grant rate is therefore one new group every 3 cycles when the release is immediate.
- x_add_o and y_add_o keep the last granted value outside BUSY; they are not cleared.
- grp_release_i outside BUSY is ignored.
- Single requester repeatedly asserting is re-granted after each GAP.
- Fairness: with all groups requesting continuously, grant order is 0,1,…,N-1,0,…
- Reset mid-BUSY: all outputs return to reset values immediately (asynchronous), and the pointer is reinitialised.

Optional Feature:
- Macro: GRP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY and clears on entering BUSY.
  - If it reaches TIMEOUT without release or abort, force the exit: enable_o=0 next edge, go to GAP, set timeout_o=1.
  - timeout_o stays set until reset.
- Undefined:
  - No counter logic; BUSY waits indefinitely for release or abort.
  - timeout_o is tied 0.

Test Plan (GRP_ROWS=2, GRP_COLS=2, GRP_ADD=1):
- Reset, then req_i=4'b0100 (index 2) → next edge: enable_o=4'b0100, x_add_o=1, y_add_o=0, busy_o=1, grant_cnt_o=1. Release pulse → enable_o=0 for one GAP cycle, then IDLE.
- req_i=4'b1111 held, release 2 cycles after each enable → enable order 0001,0010,0100,1000,0001; grant_cnt_o=5.
- In BUSY on index 1, raise req for index 3 and pulse grp_release_i in the same cycle → index 1 drops, GAP, then index 3 is granted.
- Enable index 0, then drop req_i[0] with active_i=0 and no release → enable_o=0 next edge, GAP, IDLE; grant_cnt_o unchanged afterwards.
- With GRP_TIMEOUT_EN, TIMEOUT=8: grant index 1, no release, req held with active_i=1 → after 8 BUSY cycles enable_o=0 and timeout_o=1 (sticky). Without the macro, enable_o is held and timeout_o=0.
- Assert reset_i mid-BUSY between clock edges → enable_o=0 and busy_o=0 immediately. After release of reset with req_i=4'b1000 → index 3 granted.
